// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller for the 8-bit combinational ALU: accepts one
// instruction, registers operands from a 4x8 register file, captures the result, writes back.
module alu_issue_ctrl #(
  parameter int NUM_REGS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  output logic        done,
  output logic [7:0]  wb_data,
  output logic        zero_flag,
  output logic        neg_flag,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {IDLE, OPERAND, EXECUTE, WRITEBACK} state_t;

  state_t      state, next_state;
  logic [15:0] ir;
  logic [7:0]  regs [NUM_REGS];
  logic        accept;

  logic [2:0] op;
  logic [1:0] rd, rs1, rs2;
  logic       use_imm;
  logic [7:0] imm;

  assign op      = ir[15:13];
  assign rd      = ir[12:11];
  assign rs1     = ir[10:9];
  assign use_imm = ir[8];
  assign imm     = ir[7:0];
  assign rs2     = ir[7:6];

  // instr_ready is a register, so the handshake must also qualify on it
  // (it stays low in IDLE for the first cycle after reset release).
  assign accept   = (state == IDLE) && instr_valid && instr_ready;
  assign dbg_data = regs[dbg_addr];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = OPERAND;
      OPERAND:   next_state = EXECUTE;
      EXECUTE:   next_state = WRITEBACK;
      WRITEBACK: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= next_state;
      instr_ready <= (next_state == IDLE);
      done        <= (next_state == WRITEBACK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir     <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else begin
      if (accept) ir <= instr;
      if (state == OPERAND) begin
        alu_a  <= regs[rs1];
        alu_b  <= use_imm ? imm : regs[rs2];
        alu_op <= op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data   <= '0;
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state == EXECUTE) wb_data <= alu_result;
      if (state == WRITEBACK) begin
        regs[rd]  <= wb_data;
        zero_flag <= (wb_data == 8'h00);
        neg_flag  <= wb_data[7];
      end
    end
  end

endmodule
